// File: rtl/bcd_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_disp_pkg
// Purpose  : Shared types, constants and constant functions for the scanned
//            BCD display path.
// Revision : 1.0 - initial release
// ============================================================================
package bcd_disp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Segment patterns are listed a..g, MSB = segment a, active-low
    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_ZERO = 7'b0000001;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_scan_display_bcd_module.sv
`default_nettype none
// ============================================================================
// Module   : BCD_module
// Purpose  : 4-bit BCD to active-low 7-segment decoder (a..g); non-decimal
//            codes turn every segment off.
// Revision : 1.0 - initial release
// ============================================================================
module BCD_module
    import bcd_disp_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [0:6] o_seg
);

    always_comb begin
        o_seg = SEG_OFF;
        case (i_bcd)
            4'd0:    o_seg = SEG_ZERO;
            4'd1:    o_seg = 7'b1001111;
            4'd2:    o_seg = 7'b0010010;
            4'd3:    o_seg = 7'b0000110;
            4'd4:    o_seg = 7'b1001100;
            4'd5:    o_seg = 7'b0100100;
            4'd6:    o_seg = 7'b0100000;
            4'd7:    o_seg = 7'b0001111;
            4'd8:    o_seg = 7'b0000000;
            4'd9:    o_seg = 7'b0000100;
            default: o_seg = SEG_OFF;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/bcd_scan_display.sv
`default_nettype none
// ============================================================================
// Module   : bcd_scan_display
// Purpose  : Iterative binary-to-BCD converter feeding a time-multiplexed
//            common-anode 7-segment bank with leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_scan_display
    import bcd_disp_pkg::*;
#(
    parameter int N_in        = 14,
    parameter int N_digits    = 4,
    parameter int N_out       = 7,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_in-1:0]     bin_in,
    input  logic                load,
    input  logic                blank_lz,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic [0:N_out-1]    seg,
    output logic [N_digits-1:0] an
);

    localparam int c_BCD_W = 4 * N_digits + 4;
    localparam int c_CNT_W = clog2(N_in + 1);
    localparam int c_REF_W = clog2(REFRESH_DIV);
    localparam int c_IDX_W = (N_digits > 1) ? clog2(N_digits) : 1;

    localparam logic [63:0]             c_MAX_VAL   = pow10(N_digits) - 64'd1;
    localparam logic [c_CNT_W-1:0]      c_LAST_BIT  = c_CNT_W'(N_in - 1);
    localparam logic [c_REF_W-1:0]      c_LAST_REF  = c_REF_W'(REFRESH_DIV - 1);
    localparam logic [c_IDX_W-1:0]      c_LAST_IDX  = c_IDX_W'(N_digits - 1);
    localparam logic [N_digits-1:0]     c_AN_UNIT   = N_digits'(1);
    localparam logic [4*N_digits-1:0]   c_ALL_NINES = {N_digits{4'd9}};

    state_t                 r_state, w_state_next;
    logic [N_in-1:0]        r_shift;
    logic [c_BCD_W-1:0]     r_bcd, w_adj, w_bcd_next;
    logic [c_CNT_W-1:0]     r_bit_cnt;
    logic                   r_ovf_pend, r_ovf;
    logic                   w_bin_ovf, w_ovf_now;
    logic [4*N_digits-1:0]  r_digits;

    logic [c_REF_W-1:0]     r_ref;
    logic [c_IDX_W-1:0]     r_idx, w_idx_next;
    logic [N_digits-1:0]    r_an;
    logic [0:N_out-1]       r_seg, w_seg_lit, w_seg_zero, w_seg_next;
    logic [0:6]             w_seg_dec;
    logic [3:0]             w_digit [N_digits];
    logic [N_digits-1:0]    w_zero_from;
    logic                   w_run, w_blank;

    // ---------------- conversion engine ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (load) w_state_next = CONV;
            end
            CONV: begin
                busy = 1'b1;
                if (r_bit_cnt == c_LAST_BIT) w_state_next = COMMIT;
            end
            COMMIT: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    for (genvar j = 0; j < N_digits + 1; j++) begin : g_add3
        assign w_adj[4*j +: 4] = (r_bcd[4*j +: 4] >= 4'd5) ? r_bcd[4*j +: 4] + 4'd3
                                                            : r_bcd[4*j +: 4];
    end

    assign w_bcd_next = {w_adj[c_BCD_W-2:0], r_shift[N_in-1]};
    assign w_bin_ovf  = (64'(bin_in) > c_MAX_VAL);
    // A set bit leaving the guard nibble can only mean the value is out of range
    assign w_ovf_now  = r_ovf_pend | w_adj[c_BCD_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift    <= '0;
            r_bcd      <= '0;
            r_bit_cnt  <= '0;
            r_ovf_pend <= 1'b0;
            r_digits   <= '0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (load) begin
                        r_shift    <= bin_in;
                        r_bcd      <= '0;
                        r_bit_cnt  <= '0;
                        r_ovf_pend <= w_bin_ovf;
                    end
                end
                CONV: begin
                    r_shift    <= r_shift << 1;
                    r_bcd      <= w_bcd_next;
                    r_bit_cnt  <= r_bit_cnt + c_CNT_W'(1);
                    r_ovf_pend <= w_ovf_now;
                    // Digits land on the final shift so done coincides with them
                    if (r_bit_cnt == c_LAST_BIT) begin
                        r_digits <= w_ovf_now ? c_ALL_NINES : w_bcd_next[4*N_digits-1:0];
                        r_ovf    <= w_ovf_now;
                    end
                end
                default: ;
            endcase
        end
    end

    assign overflow = r_ovf;

    // ---------------- display scanner ----------------
    for (genvar i = 0; i < N_digits; i++) begin : g_digit
        assign w_digit[i] = r_digits[4*i +: 4];
    end

    always_comb begin
        w_zero_from = '0;
        w_run       = 1'b1;
        for (int i = N_digits - 1; i >= 0; i--) begin
            w_run          = w_run & (r_digits[4*i +: 4] == 4'd0);
            w_zero_from[i] = w_run;
        end
    end

    assign w_idx_next = (r_idx == c_LAST_IDX) ? '0 : r_idx + c_IDX_W'(1);
    assign w_blank    = blank_lz && (w_idx_next != '0) && w_zero_from[w_idx_next];

    BCD_module u_dec (
        .i_bcd (w_digit[w_idx_next]),
        .o_seg (w_seg_dec)
    );

    for (genvar i = 0; i < N_out; i++) begin : g_seg_bits
        if (i < 7) begin : g_lit
            assign w_seg_lit[i]  = w_seg_dec[i];
            assign w_seg_zero[i] = SEG_ZERO[6-i];
        end else begin : g_pad
            assign w_seg_lit[i]  = 1'b1;
            assign w_seg_zero[i] = 1'b1;
        end
    end

    assign w_seg_next = w_blank ? '1 : w_seg_lit;

    // Segments are decoded for the upcoming index so seg and an move together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ref <= '0;
            r_idx <= '0;
            r_an  <= ~c_AN_UNIT;
            r_seg <= w_seg_zero;
        end else if (r_ref == c_LAST_REF) begin
            r_ref <= '0;
            r_idx <= w_idx_next;
            r_an  <= ~(c_AN_UNIT << w_idx_next);
            r_seg <= w_seg_next;
        end else begin
            r_ref <= r_ref + c_REF_W'(1);
        end
    end

    assign an  = r_an;
    assign seg = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_bcd_scan_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_scan_display
// Purpose  : Directed self-checking bench for bcd_scan_display (4 digits,
//            14-bit input, scan divider 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_scan_display;

    localparam logic [6:0] S0   = 7'b0000001;
    localparam logic [6:0] S1   = 7'b1001111;
    localparam logic [6:0] S2   = 7'b0010010;
    localparam logic [6:0] S3   = 7'b0000110;
    localparam logic [6:0] S4   = 7'b1001100;
    localparam logic [6:0] S5   = 7'b0100100;
    localparam logic [6:0] S7   = 7'b0001111;
    localparam logic [6:0] S9   = 7'b0000100;
    localparam logic [6:0] SOFF = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] bin_in;
    logic        load;
    logic        blank_lz;
    logic        busy, done, overflow;
    logic [0:6]  seg;
    logic [3:0]  an;

    int errors = 0;
    int checks = 0;

    bcd_scan_display #(
        .N_in        (14),
        .N_digits    (4),
        .N_out       (7),
        .REFRESH_DIV (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bin_in   (bin_in),
        .load     (load),
        .blank_lz (blank_lz),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .seg      (seg),
        .an       (an)
    );

    always #5 clk = ~clk;

    // Pulse load for one edge, then track busy/done after each following edge
    task automatic do_load(input logic [13:0] v, output int busy_n, output int done_at,
                           output int done_n);
        @(negedge clk);
        bin_in = v;
        load   = 1'b1;
        @(posedge clk); #1;
        load    = 1'b0;
        busy_n  = 0;
        done_at = 0;
        done_n  = 0;
        for (int n = 1; n <= 40; n++) begin
            if (n > 1) begin
                @(posedge clk); #1;
            end
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                done_at = n;
            end
            if (!busy && !done) break;
        end
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    // Capture one full scan: disp = {thousands, hundreds, tens, units}
    task automatic read_display(output logic [27:0] disp, output bit ok);
        logic [3:0] an0;
        ok   = 1'b0;
        disp = '1;
        @(posedge clk); #1;
        an0 = an;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (an !== an0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) return;
        for (int i = 0; i < 16; i++) begin
            case (an)
                4'b1110: disp[6:0]   = seg;
                4'b1101: disp[13:7]  = seg;
                4'b1011: disp[20:14] = seg;
                4'b0111: disp[27:21] = seg;
                default: ok = 1'b0;
            endcase
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_an;
        rst_n = 1'b0;
        #12;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: busy=%b done=%b ovf=%b, required 0 0 0", busy, done, overflow);
        end
        checks++;
        if (an !== 4'b1110 || seg !== S0) begin
            errors++;
            $display("FAIL reset_display: an=%b seg=%b, required 1110 %b", an, seg, S0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            @(posedge clk); #1;
            exp_an = ~(4'b0001 << ((e / 4) % 4));
            checks++;
            if (an !== exp_an || seg !== S0) begin
                errors++;
                $display("FAIL scan_idle edge %0d: an=%b seg=%b, required %b %b", e, an, seg, exp_an, S0);
            end
        end
    endtask

    task automatic test_blank_zero();
        logic [27:0] d;
        bit          ok;
        @(negedge clk);
        blank_lz = 1'b1;
        read_display(d, ok);
        checks++;
        if (!ok || d !== {SOFF, SOFF, SOFF, S0}) begin
            errors++;
            $display("FAIL blank_zero: disp=%h ok=%0d, required %h", d, ok, {SOFF, SOFF, SOFF, S0});
        end
        @(negedge clk);
        blank_lz = 1'b0;
    endtask

    task automatic test_load_1234();
        int          bn, da, dn;
        logic [27:0] d;
        bit          ok;
        do_load(14'd1234, bn, da, dn);
        checks++;
        if (bn !== 15 || da !== 15 || dn !== 1) begin
            errors++;
            $display("FAIL latency_1234: busy_cycles=%0d done_at=%0d done_pulses=%0d, required 15 15 1", bn, da, dn);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_1234: overflow=%b, required 0", overflow);
        end
        read_display(d, ok);
        checks++;
        if (!ok || d !== {S1, S2, S3, S4}) begin
            errors++;
            $display("FAIL disp_1234: disp=%h ok=%0d, required %h", d, ok, {S1, S2, S3, S4});
        end
    endtask

    task automatic test_blank_45();
        int          bn, da, dn;
        logic [27:0] d;
        bit          ok;
        @(negedge clk);
        blank_lz = 1'b1;
        do_load(14'd45, bn, da, dn);
        read_display(d, ok);
        checks++;
        if (!ok || d !== {SOFF, SOFF, S4, S5}) begin
            errors++;
            $display("FAIL disp_45_blank: disp=%h ok=%0d, required %h", d, ok, {SOFF, SOFF, S4, S5});
        end
        @(negedge clk);
        blank_lz = 1'b0;
        read_display(d, ok);
        checks++;
        if (!ok || d !== {S0, S0, S4, S5}) begin
            errors++;
            $display("FAIL disp_45_noblank: disp=%h ok=%0d, required %h", d, ok, {S0, S0, S4, S5});
        end
    endtask

    task automatic test_overflow();
        int          bn, da, dn;
        logic [27:0] d;
        bit          ok;
        do_load(14'd16383, bn, da, dn);
        checks++;
        if (overflow !== 1'b1 || dn !== 1) begin
            errors++;
            $display("FAIL ovf_16383: overflow=%b done_pulses=%0d, required 1 1", overflow, dn);
        end
        read_display(d, ok);
        checks++;
        if (!ok || d !== {S9, S9, S9, S9}) begin
            errors++;
            $display("FAIL disp_16383: disp=%h ok=%0d, required %h", d, ok, {S9, S9, S9, S9});
        end
        do_load(14'd9999, bn, da, dn);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_9999: overflow=%b, required 0", overflow);
        end
        read_display(d, ok);
        checks++;
        if (!ok || d !== {S9, S9, S9, S9}) begin
            errors++;
            $display("FAIL disp_9999: disp=%h ok=%0d, required %h", d, ok, {S9, S9, S9, S9});
        end
    endtask

    task automatic test_back_to_back();
        logic [27:0] d;
        bit          ok, seen;
        // 777 pulsed mid-conversion must be dropped
        @(negedge clk);
        bin_in = 14'd500;
        load   = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bin_in = 14'd777;
        load   = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        wait_done(seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_500: no done pulse within 40 cycles, required one");
        end
        read_display(d, ok);
        checks++;
        if (!ok || d !== {S0, S5, S0, S0}) begin
            errors++;
            $display("FAIL disp_500: disp=%h ok=%0d, required %h", d, ok, {S0, S5, S0, S0});
        end
        // Load during the done cycle is ignored; the cycle after is accepted
        @(negedge clk);
        bin_in = 14'd321;
        load   = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        wait_done(seen);
        @(negedge clk);
        bin_in = 14'd888;
        load   = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (!seen || busy !== 1'b0) begin
            errors++;
            $display("FAIL load_on_done: seen_done=%0d busy=%b, required 1 0", seen, busy);
        end
        @(negedge clk);
        bin_in = 14'd777;
        @(posedge clk); #1;
        load = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL load_after_done: busy=%b, required 1", busy);
        end
        wait_done(seen);
        read_display(d, ok);
        checks++;
        if (!seen || !ok || d !== {S0, S7, S7, S7}) begin
            errors++;
            $display("FAIL disp_777: disp=%h ok=%0d seen=%0d, required %h", d, ok, seen, {S0, S7, S7, S7});
        end
    endtask

    task automatic test_reset_mid();
        logic [27:0] d;
        bit          ok;
        bit          spurious;
        @(negedge clk);
        bin_in = 14'd8888;
        load   = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_8888: busy=%b, required 1", busy);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || an !== 4'b1110 || seg !== S0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b an=%b seg=%b, required 0 0 1110 %b",
                     busy, done, an, seg, S0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        spurious = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (busy || done) spurious = 1'b1;
        end
        checks++;
        if (spurious !== 1'b0) begin
            errors++;
            $display("FAIL abort_8888: busy/done seen after reset=%b, required 0", spurious);
        end
        read_display(d, ok);
        checks++;
        if (!ok || d !== {S0, S0, S0, S0}) begin
            errors++;
            $display("FAIL disp_after_abort: disp=%h ok=%0d, required %h", d, ok, {S0, S0, S0, S0});
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        load     = 1'b0;
        bin_in   = '0;
        blank_lz = 1'b0;
        test_reset();
        test_blank_zero();
        test_load_1234();
        test_blank_45();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
